display_scan_ctrl: RTL and testbench

Time-multiplexing controller for the 4-digit seven-segment display. It holds the 16-bit value being displayed and drives the 2-bit digit select into the nibble selector. It also drives the active-low anode enables, with a dead-time blank between digits to prevent ghosting. New display values arrive over a valid/ready handshake and are committed only at frame boundaries, so a frame never shows a mix of old and new values.

---
 rtl/display_scan_ctrl.sv | 147 ++++++++++++++
 tb/tb_display_scan_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan controller: dead-time blanked digit multiplexing,
// leading-zero blanking and a one-deep pending value committed at frame boundaries.
module display_scan_ctrl #(
  parameter int unsigned DIGIT_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        lzb,
  input  logic [15:0] upd_value,
  input  logic        upd_valid,
  output logic        upd_ready,
  output logic [15:0] value_out,
  output logic [1:0]  dig_sel,
  output logic [3:0]  an,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DIG_LAST   = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        dig_q, dig_d;
  logic [3:0]        an_q, an_d;
  logic [15:0]       value_q, value_d;
  logic [15:0]       pend_q, pend_d;
  logic              full_q, full_d;
  logic              ready_q;
  logic              fd_q, fd_d;
  logic [3:0]        blank;

  // Digit k goes dark when it and every more significant nibble are zero.
  always_comb begin
    blank    = '0;
    blank[3] = lzb && (value_q[15:12] == 4'h0);
    blank[2] = lzb && (value_q[15:8]  == 8'h00);
    blank[1] = lzb && (value_q[15:4]  == 12'h000);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    value_d = value_q;
    pend_d  = pend_q;
    full_d  = full_q;
    fd_d    = 1'b0;
    an_d    = '1;

    if (!en) begin
      state_d = S_OFF;
      cnt_d   = '0;
      dig_d   = '0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = S_BLANK;
          cnt_d   = '0;
        end
        S_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = S_DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DRIVE: begin
          if (cnt_q == DIG_LAST) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            dig_d   = dig_q + 1'b1;
            if (dig_q == 2'd3) begin
              fd_d = 1'b1;
              if (full_q) begin
                value_d = pend_q;
                full_d  = 1'b0;
              end
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_OFF;
          cnt_d   = '0;
          dig_d   = '0;
        end
      endcase
    end

    // While dark there is no frame to tear, so a pending value lands at once.
    if (state_q == S_OFF && full_q) begin
      value_d = pend_q;
      full_d  = 1'b0;
    end

    if (upd_valid && !full_q) begin
      pend_d = upd_value;
      full_d = 1'b1;
    end

    if (state_d == S_DRIVE && !blank[dig_d]) begin
      an_d = ~(4'b0001 << dig_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      dig_q   <= '0;
      an_q    <= '1;
      value_q <= '0;
      pend_q  <= '0;
      full_q  <= 1'b0;
      ready_q <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      an_q    <= an_d;
      value_q <= value_d;
      pend_q  <= pend_d;
      full_q  <= full_d;
      ready_q <= !full_d;
      fd_q    <= fd_d;
    end
  end

  assign upd_ready  = ready_q;
  assign value_out  = value_q;
  assign dig_sel    = dig_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl against a frame-position arithmetic model.
module tb_display_scan_ctrl;

  localparam int D = 4;
  localparam int B = 1;
  localparam int P = 4 * (D + B);
  localparam int N_CYC = 4000;

  logic        clk = 1'b0;
  logic        rst_n, en, lzb, upd_valid;
  logic [15:0] upd_value;
  logic        upd_ready, frame_done;
  logic [15:0] value_out;
  logic [1:0]  dig_sel;
  logic [3:0]  an;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .DIGIT_CYCLES(D),
    .BLANK_CYCLES(B),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .lzb(lzb),
    .upd_value(upd_value),
    .upd_valid(upd_valid),
    .upd_ready(upd_ready),
    .value_out(value_out),
    .dig_sel(dig_sel),
    .an(an),
    .frame_done(frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Model: time since the scan was enabled, mapped to frame position.
  bit          m_ok = 1'b0;
  bit          m_on;
  int          m_t;
  logic [15:0] m_val, m_pend;
  bit          m_full, m_fd;
  logic [3:0]  e_an;
  logic [1:0]  e_dig;

  function automatic bit lz_blank(input bit lz, input logic [15:0] v, input int k);
    int hi;
    hi = -1;
    for (int i = 0; i < 4; i++)
      if (v[4*i +: 4] != 4'h0) hi = i;
    return lz && (k > 0) && (k > hi);
  endfunction

  task automatic model_step();
    bit commit;
    int pos, slot;
    commit = 1'b0;
    if (!rst_n) begin
      m_ok = 1'b1; m_on = 1'b0; m_t = 0;
      m_val = '0; m_pend = '0; m_full = 1'b0; m_fd = 1'b0;
    end else begin
      m_fd = 1'b0;
      if (!m_on && m_full) commit = 1'b1;
      if (m_on && en && (m_t % P) == P - 1) begin
        m_fd = 1'b1;
        if (m_full) commit = 1'b1;
      end
      if (upd_valid && !m_full) begin
        m_pend = upd_value;
        m_full = 1'b1;
      end else if (commit) begin
        m_val  = m_pend;
        m_full = 1'b0;
      end
      if (!en) m_on = 1'b0;
      else if (!m_on) begin
        m_on = 1'b1;
        m_t  = 0;
      end else m_t++;
    end
    e_an  = 4'hF;
    e_dig = 2'd0;
    if (m_on) begin
      pos   = m_t % P;
      slot  = pos / (D + B);
      e_dig = 2'(slot);
      if ((pos % (D + B)) >= B && !lz_blank(lzb, m_val, slot)) e_an[slot] = 1'b0;
    end
  endtask

  initial begin
    int mode;
    rst_n = 1'b0; en = 1'b0; lzb = 1'b0; upd_valid = 1'b0; upd_value = '0;
    model_step();
    for (int i = 0; i < N_CYC; i++) begin
      @(negedge clk);
      cyc = i;
      if (m_ok) begin
        check("an", 16'(an), 16'(e_an));
        check("dig_sel", 16'(dig_sel), 16'(e_dig));
        check("value_out", value_out, m_val);
        check("upd_ready", 16'(upd_ready), 16'(!m_full));
        check("frame_done", 16'(frame_done), 16'(m_fd));
      end
      if (i < 2) begin
        rst_n = 1'b0;
      end else if (i < 100) begin
        rst_n = 1'b1;
        en    = 1'b1;
        upd_valid = (i == 30 || i == 33);
        upd_value = (i == 30) ? 16'h1234 : 16'h9999;
        lzb   = (i >= 60);
      end else begin
        rst_n = ($urandom_range(0, 249) != 0);
        if ($urandom_range(0, 39) == 0) en = ~en;
        if ($urandom_range(0, 29) == 0) lzb = ~lzb;
        upd_valid = ($urandom_range(0, 11) == 0);
        mode = $urandom_range(0, 4);
        case (mode)
          0: upd_value = 16'h0000;
          1: upd_value = 16'h0050;
          2: upd_value = 16'($urandom) & 16'h00FF;
          3: upd_value = 16'($urandom) & 16'h0FFF;
          default: upd_value = 16'($urandom);
        endcase
      end
      model_step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
